// File: rtl/parity_pkg.sv
// Shared types and constants for the streaming parity accumulator.
package parity_pkg;

  typedef enum logic {ACC, HOLD} par_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage : parity_pkg

// File: rtl/xor_reduce.sv
// Combinational parity of one word: 1 when the word holds an odd number of ones.
module xor_reduce #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity_c
);

  assign parity_c = ^data;

endmodule : xor_reduce

// File: rtl/parity_stream_acc.sv
// Streaming frame parity generator with saturating beat count and back-pressured result.
// Optional feature macro PARITY_STREAM_CHECK_EN adds exp_parity/out_err comparison.
module parity_stream_acc
  import parity_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned MAX_WORDS = 16,
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             odd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
`ifdef PARITY_STREAM_CHECK_EN
  ,
  input  logic             exp_parity,
  output logic             out_err
`endif
);

  par_state_t       state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             mode_q, mode_d;
  logic             out_parity_q, out_parity_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;
`ifdef PARITY_STREAM_CHECK_EN
  logic             out_err_q, out_err_d;
`endif

  logic             word_par_c;
  logic             beat_c;
  logic             first_c;
  logic             at_max_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             frame_mode_c;
  logic             frame_par_c;

  xor_reduce #(.WIDTH(WIDTH)) u_xor_reduce (
    .data     (in_data),
    .parity_c (word_par_c)
  );

  // cnt never wraps, so zero reliably marks the first beat of a frame
  assign beat_c       = in_valid && (state_q == ACC);
  assign first_c      = (cnt_q == '0);
  assign at_max_c     = (cnt_q == CNT_W'(MAX_WORDS));
  assign cnt_inc_c    = at_max_c ? cnt_q : cnt_q + CNT_W'(1);
  assign frame_mode_c = first_c ? odd_mode : mode_q;
  assign frame_par_c  = acc_q ^ word_par_c ^ frame_mode_c;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    mode_d       = mode_q;
    out_parity_d = out_parity_q;
    out_count_d  = out_count_q;
    out_ovf_d    = out_ovf_q;
`ifdef PARITY_STREAM_CHECK_EN
    out_err_d    = out_err_q;
`endif
    case (state_q)
      ACC: begin
        if (beat_c) begin
          if (in_last) begin
            out_parity_d = frame_par_c;
            out_count_d  = cnt_inc_c;
            out_ovf_d    = ovf_q || at_max_c;
`ifdef PARITY_STREAM_CHECK_EN
            out_err_d    = (frame_par_c != exp_parity);
`endif
            state_d      = HOLD;
          end else begin
            acc_d = acc_q ^ word_par_c;
            cnt_d = cnt_inc_c;
            if (at_max_c) ovf_d = 1'b1;
            if (first_c) mode_d = odd_mode;
          end
        end
      end
      HOLD: begin
        // No bypass: the freed slot is only advertised on the following cycle
        if (out_ready) begin
          state_d = ACC;
          acc_d   = 1'b0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACC;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      mode_q       <= PAR_EVEN;
      out_parity_q <= 1'b0;
      out_count_q  <= '0;
      out_ovf_q    <= 1'b0;
`ifdef PARITY_STREAM_CHECK_EN
      out_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      mode_q       <= mode_d;
      out_parity_q <= out_parity_d;
      out_count_q  <= out_count_d;
      out_ovf_q    <= out_ovf_d;
`ifdef PARITY_STREAM_CHECK_EN
      out_err_q    <= out_err_d;
`endif
    end
  end

  assign in_ready   = (state_q == ACC);
  assign out_valid  = (state_q == HOLD);
  assign out_parity = out_parity_q;
  assign out_count  = out_count_q;
  assign out_ovf    = out_ovf_q;
`ifdef PARITY_STREAM_CHECK_EN
  assign out_err    = out_err_q;
`endif

endmodule : parity_stream_acc

// File: tb/tb_parity_stream_acc.sv
// Scoreboard bench for parity_stream_acc (WIDTH=8, MAX_WORDS=4); also covers PARITY_STREAM_CHECK_EN.
module tb_parity_stream_acc;
  import parity_pkg::*;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_WORDS = 4;
  localparam int unsigned CNT_W     = 3;

  typedef struct packed {
    logic             par;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             odd_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
`ifdef PARITY_STREAM_CHECK_EN
  logic             exp_parity;
  logic             out_err;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic prev_valid = 1'b0;

  parity_stream_acc #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .odd_mode   (odd_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_parity (out_parity),
    .out_count  (out_count),
    .out_ovf    (out_ovf)
`ifdef PARITY_STREAM_CHECK_EN
    ,
    .exp_parity (exp_parity),
    .out_err    (out_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result for the next frame; also sets the reference parity fed to the checker
  task automatic push_exp(input logic par, input int cnt, input logic ovf, input logic err);
    exp_t e;
    e.par = par;
    e.cnt = CNT_W'(cnt);
    e.ovf = ovf;
    e.err = err;
    exp_q.push_back(e);
`ifdef PARITY_STREAM_CHECK_EN
    exp_parity = par ^ err;
`endif
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] d, input logic last, input logic mode);
    bit done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    odd_mode = mode;
    for (int k = 0; k < 50 && !done; k++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk);
      if (!done) @(negedge clk);
    end
    if (!done) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic end_frame();
    @(negedge clk);
    chk("latency_out_valid", int'(out_valid), 1);
    chk("hold_in_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    odd_mode = PAR_ODD;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_parity", int'(out_parity), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
`ifdef PARITY_STREAM_CHECK_EN
    chk("rst_out_err", int'(out_err), 0);
`endif
  endtask

  // Monitor: pop on each new result, then check it every cycle it is presented
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
        cur = '0;
      end else begin
        cur = exp_q.pop_front();
      end
    end
    if (out_valid) begin
      chk("out_parity", int'(out_parity), int'(cur.par));
      chk("out_count", int'(out_count), int'(cur.cnt));
      chk("out_ovf", int'(out_ovf), int'(cur.ovf));
`ifdef PARITY_STREAM_CHECK_EN
      chk("out_err", int'(out_err), int'(cur.err));
`endif
    end
    prev_valid = out_valid;
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    odd_mode  = PAR_EVEN;
    out_ready = 1'b1;
`ifdef PARITY_STREAM_CHECK_EN
    exp_parity = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // 1: single-beat even frame
    push_exp(1'b0, 1, 1'b0, 1'b0);
    send_beat(8'hA5, 1'b1, PAR_EVEN);
    end_frame();
    wait_idle();

    // 2: odd frame of 6 ones; mid-frame mode change ignored
    push_exp(1'b1, 3, 1'b0, 1'b0);
    send_beat(8'h01, 1'b0, PAR_ODD);
    send_beat(8'h03, 1'b0, PAR_EVEN);
    send_beat(8'h07, 1'b1, PAR_EVEN);
    end_frame();
    wait_idle();

    // 3: back-pressure with in_valid asserted during the stall
    out_ready = 1'b0;
    push_exp(1'b0, 2, 1'b0, 1'b0);
    send_beat(8'h03, 1'b0, PAR_EVEN);
    send_beat(8'h00, 1'b1, PAR_ODD);
    end_frame();
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      in_valid = 1'b1;
      in_data  = 8'h01;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", int'(out_valid), 0);
    chk("release_in_ready", int'(in_ready), 1);

    // 4: exactly MAX_WORDS beats, no overflow
    push_exp(1'b0, 4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(8'h01, i == 3, PAR_EVEN);
    end_frame();
    wait_idle();

    // 4b: 6-beat frame saturates and overflows
    push_exp(1'b0, 4, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) send_beat(8'h01, i == 5, PAR_EVEN);
    end_frame();
    wait_idle();

    // 4c: 5-beat odd frame, overflow on the last beat alone
    push_exp(1'b0, 4, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_beat(8'h01, i == 4, PAR_ODD);
    end_frame();
    wait_idle();

    // 5a: reset while a result is pending clears outputs immediately
    out_ready = 1'b0;
    push_exp(1'b1, 1, 1'b0, 1'b0);
    send_beat(8'h01, 1'b1, PAR_EVEN);
    end_frame();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // 5b: reset mid-frame discards the partial frame
    send_beat(8'h01, 1'b0, PAR_ODD);
    send_beat(8'h01, 1'b0, PAR_ODD);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(1'b0, 1, 1'b0, 1'b0);
    send_beat(8'hFF, 1'b1, PAR_EVEN);
    end_frame();
    wait_idle();

`ifdef PARITY_STREAM_CHECK_EN
    // 6: reference parity mismatch then match
    push_exp(1'b1, 1, 1'b0, 1'b1);
    send_beat(8'h01, 1'b1, PAR_EVEN);
    end_frame();
    wait_idle();
    push_exp(1'b1, 1, 1'b0, 1'b0);
    send_beat(8'h01, 1'b1, PAR_EVEN);
    end_frame();
    wait_idle();
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_parity_stream_acc
